// File: rtl/dreg_pkg.sv
// Shared mode encoding for the d_reg_chain register chain.
package dreg_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  // True for the modes that move data between stages.
  function automatic logic mode_moves(input logic [1:0] mode);
    return (mode == MODE_SHIFT) || (mode == MODE_ROTATE);
  endfunction

endpackage

// File: rtl/d_stage.sv
// One WIDTH-bit rising-edge register stage with sync reset/clear, load enable
// and a shift/rotate source select.
module d_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             sel,
  input  logic [WIDTH-1:0] d_shift,
  input  logic [WIDTH-1:0] d_rot,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= sel ? d_rot : d_shift;
    end
  end

endmodule

// File: rtl/d_reg_chain.sv
// DEPTH-stage WIDTH-bit register chain with hold/shift/rotate/clear modes,
// a saturating fill counter and an oldest-word change-detect pulse.
module d_reg_chain
  import dreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Di,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qs,
  output logic [FW-1:0]    Fill,
  output logic             Full,
  output logic             Qchg
);

  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] qs_d;
  logic             ld;
  logic             clr;
  logic             rot_sel;

  assign ld      = En && mode_moves(Mode);
  assign clr     = En && (Mode == MODE_CLEAR);
  assign rot_sel = (Mode == MODE_ROTATE);

  // Only the head stage sees two distinct sources; the rest always take the
  // previous stage, whichever direction data is moving.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      d_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (Clk),
        .rst     (Rst),
        .clr     (clr),
        .ld      (ld),
        .sel     (rot_sel),
        .d_shift (Di),
        .d_rot   (q[DEPTH-1]),
        .q       (q[0])
      );
    end else begin : g_body
      d_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (Clk),
        .rst     (Rst),
        .clr     (clr),
        .ld      (ld),
        .sel     (rot_sel),
        .d_shift (q[i-1]),
        .d_rot   (q[i-1]),
        .q       (q[i])
      );
    end
  end

  assign Qa = q[0];
  assign Qs = q[DEPTH-1];

  // Fill counts SHIFT edges only and saturates, so it can never wrap.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Fill <= '0;
    end else if (En) begin
      if (Mode == MODE_CLEAR) begin
        Fill <= '0;
      end else if ((Mode == MODE_SHIFT) && (Fill != FILL_MAX)) begin
        Fill <= Fill + FW'(1);
      end
    end
  end

  assign Full = (Fill == FILL_MAX);

  // History register tracks Qs every edge regardless of En.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      qs_d <= '0;
    end else begin
      qs_d <= Qs;
    end
  end

  assign Qchg = (Qs != qs_d);

endmodule
